// File: rtl/alu_result_fifo.sv
// Capture FIFO for packed ALU result bytes with sticky fault flags.
// Optional saturating per-push statistics when ALU_RESULT_FIFO_STATS_EN is defined.
module alu_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_sticky,
    output logic                     err_sticky,
    output logic                     carry_sticky,
`ifdef ALU_RESULT_FIFO_STATS_EN
    output logic                     ovf_sticky,
    output logic [7:0]               err_count,
    output logic [7:0]               zero_count
`else
    output logic                     ovf_sticky
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              push;
    logic              pop;
    logic              err_set;
    logic              carry_set;
    logic              ovf_set;

    // Handshake outputs depend only on registered occupancy.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign count     = count_q;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign err_set   = push && in_data[4];
    assign carry_set = push && in_data[6];
    assign ovf_set   = in_valid && !in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A set condition in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky   <= 1'b0;
            carry_sticky <= 1'b0;
            ovf_sticky   <= 1'b0;
        end else begin
            err_sticky   <= (err_sticky   && !clr_sticky) || err_set;
            carry_sticky <= (carry_sticky && !clr_sticky) || carry_set;
            ovf_sticky   <= (ovf_sticky   && !clr_sticky) || ovf_set;
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    logic zero_set;
    assign zero_set = push && in_data[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count  <= 8'd0;
            zero_count <= 8'd0;
        end else if (clr_sticky) begin
            err_count  <= err_set  ? 8'd1 : 8'd0;
            zero_count <= zero_set ? 8'd1 : 8'd0;
        end else begin
            if (err_set && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (zero_set && (zero_count != 8'hFF)) begin
                zero_count <= zero_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: fixed vector table, directed corner
// sequences and random traffic compared against a queue-based reference model.
module tb_alu_result_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       clr_sticky;
    logic       err_sticky;
    logic       carry_sticky;
    logic       ovf_sticky;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [7:0] err_count;
    logic [7:0] zero_count;
`endif

    alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .clr_sticky   (clr_sticky),
        .err_sticky   (err_sticky),
        .carry_sticky (carry_sticky),
`ifdef ALU_RESULT_FIFO_STATS_EN
        .ovf_sticky   (ovf_sticky),
        .err_count    (err_count),
        .zero_count   (zero_count)
`else
        .ovf_sticky   (ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_err;
    logic       m_carry;
    logic       m_ovf;
    int         m_err_cnt;
    int         m_zero_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit full;
        bit empty;
        bit do_push;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        if (rst) begin
            m_q.delete();
            m_err = 0; m_carry = 0; m_ovf = 0;
            m_err_cnt = 0; m_zero_cnt = 0;
        end else begin
            do_push = in_valid && !full;
            if (out_ready && !empty) void'(m_q.pop_front());
            if (do_push) m_q.push_back(in_data);
            m_err   = (m_err   && !clr_sticky) || (do_push && in_data[4]);
            m_carry = (m_carry && !clr_sticky) || (do_push && in_data[6]);
            m_ovf   = (m_ovf   && !clr_sticky) || (in_valid && full);
            if (clr_sticky) begin
                m_err_cnt  = (do_push && in_data[4]) ? 1 : 0;
                m_zero_cnt = (do_push && in_data[7]) ? 1 : 0;
            end else begin
                if (do_push && in_data[4] && m_err_cnt < 255) m_err_cnt++;
                if (do_push && in_data[7] && m_zero_cnt < 255) m_zero_cnt++;
            end
        end
    endtask

    task automatic model_check();
        chk("count",     32'(count),     32'(m_q.size()));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("out_data",  32'(out_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk("in_ready",  32'(in_ready),  32'(m_q.size() < DEPTH));
        chk("err_sticky",   32'(err_sticky),   32'(m_err));
        chk("carry_sticky", 32'(carry_sticky), 32'(m_carry));
        chk("ovf_sticky",   32'(ovf_sticky),   32'(m_ovf));
`ifdef ALU_RESULT_FIFO_STATS_EN
        chk("err_count",  32'(err_count),  32'(m_err_cnt));
        chk("zero_count", 32'(zero_count), 32'(m_zero_cnt));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                         input logic ordy, input logic clr);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy; clr_sticky = clr;
    endtask

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       clr;
        logic [3:0] e_cnt;
        logic [7:0] e_dout;
        logic       e_ov;
        logic       e_err;
        logic       e_car;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        //            rst iv din    ordy clr cnt dout  ov err car ovf
        vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,8'h05,1'b0,1'b0,4'd1,8'h05,1'b1,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,8'h4A,1'b0,1'b0,4'd2,8'h05,1'b1,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b1,8'h90,1'b0,1'b0,4'd3,8'h05,1'b1,1'b1,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,4'd2,8'h4A,1'b1,1'b1,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,4'd1,8'h90,1'b1,1'b1,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,4'd0,8'h00,1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,8'h90,1'b0,1'b1,4'd1,8'h90,1'b1,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,8'h00,1'b0,1'b1,4'd1,8'h90,1'b1,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b1,8'h40,1'b0,1'b0,4'd2,8'h90,1'b1,1'b0,1'b1,1'b0};
        vecs[13] = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,1'b0};

        m_err = 0; m_carry = 0; m_ovf = 0; m_err_cnt = 0; m_zero_cnt = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d_count", i),  32'(count),        32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_data", i),   32'(out_data),     32'(vecs[i].e_dout));
            chk($sformatf("vec%0d_valid", i),  32'(out_valid),    32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_err", i),    32'(err_sticky),   32'(vecs[i].e_err));
            chk($sformatf("vec%0d_carry", i),  32'(carry_sticky), 32'(vecs[i].e_car));
            chk($sformatf("vec%0d_ovf", i),    32'(ovf_sticky),   32'(vecs[i].e_ovf));
        end

        // Fill to full, then a write attempt with a concurrent pop must be dropped.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        chk("drop_count", 32'(count), 32'd7);
        chk("drop_ovf", 32'(ovf_sticky), 32'd1);
        chk("drop_head", 32'(out_data), 32'h02);
        for (int i = 2; i <= DEPTH; i++) begin
            chk($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        chk("drain_empty_valid", 32'(out_valid), 32'd0);
        chk("drain_no_ff", 32'(out_data), 32'h00);

        // Hold occupancy at 4 with simultaneous push/pop; pointers wrap repeatedly.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
            tick();
            chk($sformatf("steady4_%0d", i), 32'(count), 32'd4);
        end
        chk("steady_head", 32'(out_data), 32'h30);

        // Reset with 5 entries stored discards everything.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        drive(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // Random traffic in phases with different producer/consumer rates.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 300; i++) begin
                drive(($urandom_range(0, 127) == 0),
                      ($urandom_range(0, 3) < (ph == 0 ? 3 : 1)),
                      8'($urandom),
                      ($urandom_range(0, 3) < (ph == 1 ? 3 : (ph == 0 ? 1 : 2))),
                      ($urandom_range(0, 15) == 0));
                tick();
            end
        end

`ifdef ALU_RESULT_FIFO_STATS_EN
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 8'h90, 1'b1, 1'b0);
            tick();
        end
        chk("sat_err_count", 32'(err_count), 32'd255);
        chk("sat_zero_count", 32'(zero_count), 32'd255);
        drive(1'b0, 1'b1, 8'h90, 1'b1, 1'b1);
        tick();
        chk("clr_inc_err_count", 32'(err_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
Downstream capture stage for the 4-bit custom ALU. Accepts the ALU's packed output byte {Zero, Carry, Sign, Error, Result[3:0]} under a valid/ready handshake and buffers it in a FIFO for later readback. Maintains sticky status flags so host firmware can poll for faults without draining the buffer.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2.
DATA_W, 8, entry width; fixed to the ALU output byte layout.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  producer has an ALU result on in_data.
in_ready  output  1  FIFO can accept an entry (high when not full).
in_data  input  8  [7] Zero, [6] Carry, [5] Sign, [4] Error, [3:0] Result.
out_valid  output  1  head entry available (high when not empty).
out_ready  input  1  consumer takes the head entry this cycle.
out_data  output  8  head entry; show-ahead; 0 when empty.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
clr_sticky  input  1  one-cycle pulse that clears the sticky flags.
err_sticky  output  1  set when any accepted entry has Error=1.
carry_sticky  output  1  set when any accepted entry has Carry=1.
ovf_sticky  output  1  set when in_valid is high while the FIFO is full (dropped write).

Behaviour:
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, in_ready=1, out_valid=0, out_data=0, all sticky flags=0. Memory contents are don't-care. Reset mid-transfer discards all entries; no partial state survives.
- Push: occurs when in_valid && in_ready. in_data is written at mem[wr_ptr], wr_ptr increments (mod DEPTH), and count increments.
- Pop: occurs when out_valid && out_ready. rd_ptr increments (mod DEPTH) and count decrements.
- Simultaneous push and pop: count is unchanged and both pointers advance. Legal at any occupancy 1..DEPTH-1.
- Full (count==DEPTH): in_ready=0 and push is blocked, even if out_ready is high the same cycle. No write-through. ovf_sticky sets if in_valid=1.
- Empty (count==0): out_valid=0 and out_data=0. out_ready is ignored. There is no bypass: an entry pushed at edge N appears on out_data/out_valid after edge N, i.e. 1-cycle latency.
- in_ready, out_valid and count are registered or derived from registered state only. No combinational path from in_valid or out_ready to any output.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is held separately to disambiguate full from empty.
- Sticky flags:
  - err_sticky sets on a push with in_data[4]=1.
  - carry_sticky sets on a push with in_data[6]=1.
  - Flags hold until clr_sticky.
  - If clr_sticky and a set condition occur in the same cycle, set wins and the flag is 1 afterwards.
- The block performs no data transformation; entries are stored bit-exact.

Optional Feature:
Macro ALU_RESULT_FIFO_STATS_EN.
- Defined: adds output err_count[7:0] and output zero_count[7:0].
  - err_count increments on each push with Error=1; zero_count increments on each push with Zero=1.
  - Both counters saturate at 255.
  - Both reset to 0 on rst and on clr_sticky. A clr and an increment in the same cycle give a result of 1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle -> count=0, out_valid=0, out_data=8'h00, in_ready=1, all sticky flags=0.
- Push 8'h05, 8'h4A, 8'h90 on consecutive cycles with out_ready=0 -> count=3. Then pop 3 with out_ready=1 -> out_data 8'h05, 8'h4A, 8'h90 in order, then out_valid=0.
- Fill to 8 entries (8'h01..8'h08), then drive in_valid=1 with 8'hFF while out_ready=1 -> in_ready=0 and 8'hFF is dropped. After the pop, count=7 and ovf_sticky=1.
- Hold count=4 with push and pop asserted together for 20 cycles (incrementing data) -> count stays 4, pointers wrap, output order is preserved.
- Push 8'h90 (Zero, Error) in the same cycle as a clr_sticky pulse -> err_sticky=1. Next cycle, clr_sticky alone -> err_sticky=0. Push 8'h40 -> carry_sticky=1.
- Assert rst with 5 entries stored -> next cycle count=0, out_valid=0. With STATS_EN defined, push 300 entries of 8'h90 across drains -> err_count=zero_count=255.
